// File: rtl/if_fetch_if.sv
// Instruction-memory port between the fetch stage (master) and instruction memory (slave).
// req/addr are held stable from the rising edge of req until the cycle rdy is high.
interface if_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        rdy;
  logic [31:0] data;

  modport master (output req, output addr, input rdy, input data);
  modport slave  (input req, input addr, output rdy, output data);
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem req/rdy handshake and selects next PC
// among sequential, branch, interrupt vector and EPC return; emits NOP bubbles when idle.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] INTR_VEC = 32'h0000_0008,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stall,
  input  logic        pcsrc,
  input  logic [31:0] bpc,
  input  logic        intr,
  input  logic        eret,
  input  logic [31:0] epc,
  if_fetch_if.master  imem,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign redirect = intr | eret | pcsrc;
  assign target   = intr ? INTR_VEC : (eret ? epc : bpc);
  assign pc_inc   = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_inst_d  = hold_inst_q;
    drain_addr_d = drain_addr_q;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem.rdy) begin
          if (redirect) begin
            pc_d = target;
          end else if (stall) begin
            hold_inst_d = imem.data;
            state_d     = StHold;
          end else begin
            pc_d = pc_inc;
          end
        end else if (redirect) begin
          // Request already issued: keep its address on the bus until memory answers.
          pc_d         = target;
          drain_addr_d = pc_q;
          state_d      = StDrain;
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d    = target;
          state_d = StFetch;
        end else if (!stall) begin
          pc_d    = pc_inc;
          state_d = StFetch;
        end
      end
      StDrain: begin
        if (redirect) pc_d = target;
        if (imem.rdy) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      hold_inst_q  <= NOP_INST;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_inst_q  <= hold_inst_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  assign imem.req  = (state_q == StFetch) || (state_q == StDrain);
  assign imem.addr = (state_q == StDrain) ? drain_addr_q : pc_q;
  assign if_pc     = pc_q;
  assign if_pc4    = pc_inc;

  always_comb begin
    if_valid = 1'b0;
    if_inst  = NOP_INST;
    if (!redirect) begin
      if (state_q == StFetch && imem.rdy) begin
        if_valid = 1'b1;
        if_inst  = imem.data;
      end else if (state_q == StHold) begin
        if_valid = 1'b1;
        if_inst  = hold_inst_q;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Random-stimulus bench for if_fetch: expected instruction stream kept as a queue of PCs,
// consumed by a monitor whenever the stage hands an instruction to decode.
module tb_if_fetch;
  localparam logic [31:0] ResetPc   = 32'h0000_0000;
  localparam logic [31:0] IntrVec   = 32'h0000_0008;
  localparam logic [31:0] NopInst   = 32'h0000_0000;
  localparam int          NumCycles = 3000;

  logic        clk = 1'b0;
  logic        clr, stall, pcsrc, intr, eret, rdy;
  logic [31:0] bpc, epc, junk;
  logic [31:0] if_pc, if_pc4, if_inst;
  logic        if_valid;
  logic        post_rst;

  int n_chk  = 0;
  int n_pass = 0;
  int n_acc  = 0;

  logic [31:0] exp_q[$];

  if_fetch_if imem_bus ();

  if_fetch #(
    .RESET_PC (ResetPc),
    .INTR_VEC (IntrVec),
    .NOP_INST (NopInst)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .stall    (stall),
    .pcsrc    (pcsrc),
    .bpc      (bpc),
    .intr     (intr),
    .eret     (eret),
    .epc      (epc),
    .imem     (imem_bus),
    .if_pc    (if_pc),
    .if_pc4   (if_pc4),
    .if_inst  (if_inst),
    .if_valid (if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // Memory: correct word only while rdy, garbage otherwise so stale data cannot pass.
  assign imem_bus.rdy = rdy;
  always_comb imem_bus.data = rdy ? mem_word(imem_bus.addr) : junk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0040;
      1:       return 32'h0000_0100;
      2:       return 32'hFFFF_FFF4;
      default: return r & 32'h0000_FFFC;
    endcase
  endfunction

  // Driver: sets inputs #1 after each posedge and updates the expected PC stream.
  initial begin
    clr = 1'b1; stall = 1'b0; pcsrc = 1'b0; intr = 1'b0; eret = 1'b0;
    bpc = '0; epc = '0; rdy = 1'b0; junk = '0; post_rst = 1'b0;
    exp_q.push_back(ResetPc);
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < NumCycles; c++) begin
      post_rst = clr;
      clr   = 1'b0;
      junk  = $urandom;
      intr  = 1'b0; eret = 1'b0; pcsrc = 1'b0;
      bpc   = pick_target();
      epc   = pick_target();
      if (post_rst) begin
        stall = 1'b0;
        rdy   = 1'b1;
      end else if (c < 6) begin
        stall = 1'b0;
        rdy   = 1'b1;
      end else if (c < 8) begin
        stall = 1'b0;
        rdy   = 1'b0;
      end else if (c % 700 == 349) begin
        stall = 1'b0;
        rdy   = 1'b0;
        pcsrc = 1'b1;
      end else if (c % 700 == 350) begin
        clr   = 1'b1;
        stall = 1'b1;
        rdy   = $urandom_range(0, 1) == 1;
      end else begin
        stall = $urandom_range(0, 99) < 20;
        rdy   = $urandom_range(0, 99) < 75;
        intr  = $urandom_range(0, 99) < 3;
        eret  = $urandom_range(0, 99) < 4;
        pcsrc = $urandom_range(0, 99) < 8;
      end
      if (clr) begin
        exp_q.delete();
        exp_q.push_back(ResetPc);
      end else if (intr || eret || pcsrc) begin
        exp_q.delete();
        exp_q.push_back(intr ? IntrVec : (eret ? epc : bpc));
      end
      while (exp_q.size() < 4) exp_q.push_back(exp_q[$] + 32'd4);
      @(posedge clk);
      #1;
    end
    check("accepted_count_min", 32'(n_acc > 300), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  logic        prev_pending = 1'b0;
  logic [31:0] prev_addr    = '0;
  logic [31:0] exp_pc;

  // Monitor: samples combinational outputs mid-cycle.
  always @(negedge clk) begin
    if (clr) begin
      prev_pending = 1'b0;
    end else if (post_rst) begin
      check("rst_req", 32'(imem_bus.req), 32'd0);
      check("rst_valid", 32'(if_valid), 32'd0);
      check("rst_inst", if_inst, NopInst);
      check("rst_pc", if_pc, ResetPc);
      check("rst_pc4", if_pc4, ResetPc + 32'd4);
      prev_pending = 1'b0;
    end else begin
      if (intr || eret || pcsrc) check("valid_on_redirect", 32'(if_valid), 32'd0);
      if (!if_valid) check("bubble_inst", if_inst, NopInst);
      if (prev_pending) begin
        check("hs_req_held", 32'(imem_bus.req), 32'd1);
        check("hs_addr_held", imem_bus.addr, prev_addr);
      end
      if (if_valid && !stall) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
          exp_pc = exp_q.pop_front();
          check("accept_pc", if_pc, exp_pc);
          check("accept_pc4", if_pc4, exp_pc + 32'd4);
          check("accept_inst", if_inst, mem_word(exp_pc));
          n_acc++;
        end
      end
      prev_pending = imem_bus.req && !rdy;
      prev_addr    = imem_bus.addr;
    end
  end

endmodule
